// File: rtl/mips_pc_unit_ras.sv
// rtl/mips_pc_unit_ras.sv - MIPS program counter / next-PC unit with return-address stack
//
// Purpose: holds the fetch PC, selects the next PC from exception / stall / jr /
// jump / branch / sequential sources, and keeps a circular return-address stack
// that tracks call depth and flags return mispredicts.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   stall_i              hold PC and RAS
//   exception_i          vector to EXC_VECTOR, flush RAS (beats stall_i)
//   branch_i/branch_ne_i beq/bne select, zero_flag_i from the ALU
//   imm_ext_i            sign-extended word offset for branches
//   jump_i/jal_i/jr_i    j, jal, jr, jalr decode
//   instr_index_i        26-bit jump index
//   jr_target_i          register jump target (always the real jr destination)
//   pc_o, pc_plus4_o     current PC and PC+4 (link value)
//   ras_top_o            top entry, 0 when empty
//   ras_empty_o/full_o   stack occupancy flags
//   ras_mispredict_o     one-cycle pulse after a failed return prediction

module mips_pc_unit_ras #(
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] RESET_VECTOR = DATA_W'(32'h0000_0000),
  parameter logic [DATA_W-1:0] EXC_VECTOR   = DATA_W'(32'h8000_0180),
  parameter int                RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              exception_i,
  input  logic              branch_i,
  input  logic              branch_ne_i,
  input  logic              zero_flag_i,
  input  logic [DATA_W-1:0] imm_ext_i,
  input  logic              jump_i,
  input  logic              jal_i,
  input  logic              jr_i,
  input  logic [25:0]       instr_index_i,
  input  logic [DATA_W-1:0] jr_target_i,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic [DATA_W-1:0] ras_top_o,
  output logic              ras_empty_o,
  output logic              ras_full_o,
  output logic              ras_mispredict_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] pc_next;
  logic              branch_taken;

  logic [DATA_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;
  logic [PTR_W-1:0]  ras_ptr_m1;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_empty;
  logic              ras_full;

  logic              do_push;
  logic              do_pop;
  logic              do_jalr;

  assign pc_plus4     = pc_q + DATA_W'(4);
  assign branch_taken = branch_i & (zero_flag_i ^ branch_ne_i);

  always_comb begin
    pc_next = pc_plus4;
    if (exception_i) begin
      pc_next = EXC_VECTOR;
    end else if (stall_i) begin
      pc_next = pc_q;
    end else if (jr_i) begin
      pc_next = jr_target_i;
    end else if (jump_i) begin
      pc_next = {pc_plus4[DATA_W-1:28], instr_index_i, 2'b00};
    end else if (branch_taken) begin
      pc_next = pc_plus4 + (imm_ext_i << 2);
    end
  end

  // ptr always points at the next free slot; the top lives one below it and
  // wraps naturally because RAS_DEPTH is a power of two.
  assign ras_ptr_m1 = ras_ptr - PTR_W'(1);
  assign ras_empty  = (ras_count == '0);
  assign ras_full   = (ras_count == CNT_W'(RAS_DEPTH));

  assign do_push = jal_i & ~jr_i;
  assign do_pop  = jr_i & ~jal_i;
  assign do_jalr = jr_i & jal_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q             <= RESET_VECTOR;
      ras_ptr          <= '0;
      ras_count        <= '0;
      ras_mispredict_o <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem[i] <= '0;
      end
    end else begin
      pc_q             <= pc_next;
      ras_mispredict_o <= 1'b0;
      if (exception_i) begin
        // Flush only resets occupancy; stale entries are hidden by count==0.
        ras_ptr   <= '0;
        ras_count <= '0;
      end else if (!stall_i) begin
        if (do_push || (do_jalr && ras_empty)) begin
          // A push into a full stack silently overwrites the oldest entry.
          ras_mem[ras_ptr] <= pc_plus4;
          ras_ptr          <= ras_ptr + PTR_W'(1);
          if (!ras_full) begin
            ras_count <= ras_count + CNT_W'(1);
          end
        end else if (do_pop) begin
          if (ras_empty) begin
            ras_mispredict_o <= 1'b1;
          end else begin
            ras_mispredict_o <= (ras_mem[ras_ptr_m1] != jr_target_i);
            ras_ptr          <= ras_ptr_m1;
            ras_count        <= ras_count - CNT_W'(1);
          end
        end else if (do_jalr) begin
          // jalr returns and calls at once: check the top, then replace it.
          ras_mispredict_o     <= (ras_mem[ras_ptr_m1] != jr_target_i);
          ras_mem[ras_ptr_m1] <= pc_plus4;
        end
      end
    end
  end

  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_plus4;
  assign ras_top_o   = ras_empty ? '0 : ras_mem[ras_ptr_m1];
  assign ras_empty_o = ras_empty;
  assign ras_full_o  = ras_full;

endmodule

// File: tb/tb_mips_pc_unit_ras.sv
// tb/tb_mips_pc_unit_ras.sv - scoreboard testbench for mips_pc_unit_ras
module tb_mips_pc_unit_ras;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RSTV  = 32'h0000_0000;
  localparam logic [31:0] EXCV  = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, exception_i, branch_i, branch_ne_i, zero_flag_i;
  logic [31:0] imm_ext_i;
  logic        jump_i, jal_i, jr_i;
  logic [25:0] instr_index_i;
  logic [31:0] jr_target_i;
  logic [31:0] pc_o, pc_plus4_o, ras_top_o;
  logic        ras_empty_o, ras_full_o, ras_mispredict_o;

  mips_pc_unit_ras #(
    .DATA_W(32), .RESET_VECTOR(RSTV), .EXC_VECTOR(EXCV), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .exception_i(exception_i),
    .branch_i(branch_i), .branch_ne_i(branch_ne_i), .zero_flag_i(zero_flag_i),
    .imm_ext_i(imm_ext_i), .jump_i(jump_i), .jal_i(jal_i), .jr_i(jr_i),
    .instr_index_i(instr_index_i), .jr_target_i(jr_target_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .ras_top_o(ras_top_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o),
    .ras_mispredict_o(ras_mispredict_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] top;
    logic        empty;
    logic        full;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: a plain bounded stack of return addresses.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_top();
    return (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1];
  endfunction

  task automatic model_reset();
    m_pc = RSTV;
    m_ras.delete();
    m_mis = 1'b0;
  endtask

  task automatic idle_inputs();
    stall_i = 0; exception_i = 0; branch_i = 0; branch_ne_i = 0; zero_flag_i = 0;
    imm_ext_i = 0; jump_i = 0; jal_i = 0; jr_i = 0; instr_index_i = 0; jr_target_i = 0;
  endtask

  // Called just after a negedge: apply inputs, predict the post-edge state,
  // queue it for the monitor, then move to the next negedge.
  task automatic drive(input logic exc, input logic stl, input logic br, input logic bne,
                       input logic z, input logic [31:0] imm, input logic jmp,
                       input logic jl, input logic jrr, input logic [25:0] idx,
                       input logic [31:0] tgt);
    logic [31:0] p4, npc;
    exp_t        e;
    exception_i = exc; stall_i = stl; branch_i = br; branch_ne_i = bne; zero_flag_i = z;
    imm_ext_i = imm; jump_i = jmp; jal_i = jl; jr_i = jrr; instr_index_i = idx; jr_target_i = tgt;
    p4 = m_pc + 32'd4;
    if (exc)                 npc = EXCV;
    else if (stl)            npc = m_pc;
    else if (jrr)            npc = tgt;
    else if (jmp)            npc = {p4[31:28], idx, 2'b00};
    else if (br && (z != bne)) npc = p4 + imm * 32'd4;
    else                     npc = p4;
    m_mis = 1'b0;
    if (exc) begin
      m_ras.delete();
    end else if (!stl) begin
      if (jl && !jrr) begin
        m_ras.push_back(p4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (jrr && !jl) begin
        if (m_ras.size() == 0) m_mis = 1'b1;
        else begin
          m_mis = (m_top() != tgt);
          void'(m_ras.pop_back());
        end
      end else if (jrr && jl) begin
        if (m_ras.size() == 0) m_ras.push_back(p4);
        else begin
          m_mis = (m_top() != tgt);
          m_ras[m_ras.size()-1] = p4;
        end
      end
    end
    m_pc    = npc;
    e.pc    = npc;
    e.top   = m_top();
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    e.mis   = m_mis;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_jr(input logic [31:0] t);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, t);
  endtask
  task automatic do_jal(input logic [25:0] idx);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, idx, 0);
  endtask

  // Monitor: every clock the DUT presents a new state; compare it with the
  // oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc_o, e.pc);
        chk("pc_plus4", pc_plus4_o, e.pc + 32'd4);
        chk("ras_top", ras_top_o, e.top);
        chk("ras_empty", 32'(ras_empty_o), 32'(e.empty));
        chk("ras_full", 32'(ras_full_o), 32'(e.full));
        chk("mispredict", 32'(ras_mispredict_o), 32'(e.mis));
      end
    end
  end

  initial begin
    int op;
    logic [31:0] t;
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_pc", pc_o, RSTV);
    chk("reset_empty", 32'(ras_empty_o), 32'd1);
    chk("reset_top", ras_top_o, 32'd0);
    chk("reset_mis", 32'(ras_mispredict_o), 32'd0);
    reset = 1'b1;
    model_reset();

    // Sequential fetch out of reset, then reset mid-run at pc=0x40.
    do_idle(); do_idle(); do_idle();
    do_jr(32'h40);
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    chk("midrst_pc", pc_o, RSTV);
    chk("midrst_empty", 32'(ras_empty_o), 32'd1);
    chk("midrst_mis", 32'(ras_mispredict_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    do_idle(); do_idle(); do_idle();

    // bne back by two words, then same with zero=1 (not taken).
    do_jr(32'h10);
    drive(0, 0, 1, 1, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    do_jr(32'h10);
    drive(0, 0, 1, 1, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    // beq taken forward.
    drive(0, 0, 1, 0, 1, 32'h0000_0003, 0, 0, 0, 0, 0);

    // Address wrap.
    do_jr(32'hFFFF_FFFC);
    do_idle();

    // jal / matching jr.
    do_jr(32'h1000_0000);
    do_jal(26'h40);
    do_jr(32'h1000_0004);

    // Overflow the stack, drain it, one pop too many.
    for (int i = 0; i < 5; i++) do_jal(26'h100 + 26'(i * 16));
    for (int i = 0; i < 5; i++) do_jr(m_top());
    do_idle();

    // Wrong return target, then stall with jump.
    do_jal(26'h222);
    do_jr(32'h0000_0BAD);
    do_idle();
    do_jal(26'h333);
    drive(0, 1, 0, 0, 0, 0, 1, 0, 0, 26'h3FF_FFFF, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234_5678);

    // jalr on empty, jalr matching, jalr mismatching.
    do_jr(m_top());
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0000_0500);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, m_top());
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0000_0700);

    // Exception while stalled with three entries.
    do_jal(26'h11); do_jal(26'h22); do_jal(26'h33);
    drive(1, 1, 0, 0, 0, 0, 1, 1, 0, 26'h44, 0);
    do_jr(32'h0000_0100);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 5));
      t  = ($urandom_range(0, 1) == 1 && m_ras.size() > 0) ? m_top() : ($urandom & 32'hFFFF_FFFC);
      drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 7) == 0),
            (op == 1), 1'($urandom), 1'($urandom), $urandom,
            (op == 2 || op == 3), (op == 3 || op == 5), (op == 4 || op == 5),
            26'($urandom), t);
    end

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
